isqrt_seq: RTL and testbench
============================

Name: isqrt_seq

Overview:
- Sequential integer square root, the inverse of the lab's combinational squarer.
- Accepts a WIDTH-bit unsigned operand. Returns floor(sqrt(x)), the remainder x - root², and a perfect-square flag.
- Uses the digit-by-digit restoring method: one root bit per clock, with valid/ready handshakes on both sides.
- With WIDTH=6 it decodes any squarer output (0..63) back to the 3-bit number.

Parameters:
- WIDTH, 6, operand width in bits; must be even and ≥2. N = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept operand
- in_num  input  WIDTH  unsigned operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- root  output  N  floor(sqrt(in_num))
- rem  output  N+1  in_num - root²
- exact  output  1  1 when rem == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, root=0, rem=0, exact=0, internal operand/counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_num and clear the root and remainder accumulators. Load iteration counter with N-1, go to CALC.
  - CALC: in_ready=0. One iteration per edge, MSB pair first:
    - r' = (r<<2) | next two operand bits
    - t = (q<<2) | 1
    - if r' ≥ t: r = r' - t, q = (q<<1) | 1; else r = r', q = q<<1
    - Shift operand left by 2. At counter==0 after that iteration, go to DONE; else decrement.
  - DONE: out_valid=1; root/rem/exact driven from registers and stable. On out_ready, go to IDLE, out_valid drops on that edge.
- Latency:
  - Accept edge E0; iterations on E1..EN; out_valid high after EN.
  - For WIDTH=6, out_valid is observed 3 cycles after acceptance. Minimum throughput is one result per N+2 cycles.
- Widths:
  - Working remainder is N+3 bits, trial value N+2 bits; no overflow is possible.
  - Final rem ≤ 2·root, so it fits in N+1 bits. Upper working bits must be zero at DONE; the bench asserts this.
- Handshake rules:
  - in_ready is combinational from state (IDLE only).
  - in_num is ignored outside the accept edge; changes during CALC have no effect.
  - out_valid never drops without out_ready; outputs are held under backpressure indefinitely.
  - No new operand is accepted while CALC or DONE, including the edge where out_ready is sampled. The next acceptance happens in IDLE.
- Boundary cases:
  - in_num=0 → root 0, rem 0, exact 1.
  - in_num = 2^WIDTH-1 → root 2^N-1, rem 2^(N+1)-2.
  - in_valid held high continuously → back-to-back operations separated by the IDLE cycle.
- Reset mid-operation: rst_n low in CALC or DONE aborts immediately to reset values. No partial result is ever presented.
- root, rem and exact hold their last values in IDLE. They are valid only while out_valid=1.

Decomposition:
- Shared package/header:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2
  - default WIDTH
  - a ROOT_W = WIDTH/2 helper constant
- Sub-module isqrt_step: purely combinational single iteration. Inputs r, q and a 2-bit operand pair; outputs next r and next q. Instanced once in isqrt_seq and reusable for an unrolled variant.
- isqrt_seq holds the FSM, counter, operand shift register and handshake logic.

Test Plan:
- WIDTH=6, in_num=36, out_ready=1 → out_valid exactly 3 cycles after acceptance; root=6, rem=0, exact=1; in_ready=0 from accept until return to IDLE.
- in_num=63 → root=7, rem=14, exact=0. in_num=10 → root=3, rem=1, exact=0. in_num=0 → root=0, rem=0, exact=1.
- Backpressure with in_num=49 and out_ready=0 for 5 cycles → out_valid stays 1 and root=7, rem=0 stay stable. A second in_valid during this window is not accepted. Release out_ready → next operand accepted only from IDLE.
- Pull rst_n low during CALC of in_num=50, then release → all outputs at reset values, in_ready=1. A following in_num=25 gives root=5, rem=0, exact=1.
- Exhaustive 0..63 with random out_ready and in_valid gaps → for each result root²+rem == in_num, rem ≤ 2·root, exact == (rem==0). Also square(root) from the squarer module equals in_num whenever exact=1.
- WIDTH=8 regression, in_num=255 → root=15, rem=30, out_valid 4 cycles after acceptance.

Source files
------------

// File: rtl/isqrt_seq_pkg.sv
// Shared constants for the sequential integer square root: FSM encoding,
// default operand width and the derived root width.
package isqrt_seq_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int ROOT_W    = DEF_WIDTH / 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Iteration counter width; at least one bit so N=1 still elaborates.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration, purely combinational.
// Brings in one operand bit pair and produces one more root bit.
module isqrt_step #(
    parameter int N = 3
) (
    input  logic [N+2:0] i_r,
    input  logic [N-1:0] i_q,
    input  logic [1:0]   i_pair,
    output logic [N+2:0] o_r,
    output logic [N-1:0] o_q
);

    logic [N+2:0] w_r_sh;
    logic [N+2:0] w_t;
    logic         w_ge;

    assign w_r_sh = (i_r << 2) | (N+3)'(i_pair);
    assign w_t    = {1'b0, i_q, 2'b01};
    assign w_ge   = (w_r_sh >= w_t);

    assign o_r = w_ge ? (w_r_sh - w_t) : w_r_sh;
    assign o_q = (i_q << 1) | N'(w_ge);

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(in_num)) with remainder: N=WIDTH/2 cycles per root,
// in_ready only in IDLE, result held in DONE until out_ready.
module isqrt_seq
    import isqrt_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_num,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               exact
);

    localparam int N  = WIDTH / 2;
    localparam int CW = cnt_w(N);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_num;
    logic [CW-1:0]    r_cnt;
    logic [N+2:0]     r_r;
    logic [N-1:0]     r_q;
    logic             r_exact;
    logic [N+2:0]     w_r_nxt;
    logic [N-1:0]     w_q_nxt;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == ST_CALC) && (r_cnt == '0);

    isqrt_step #(.N(N)) u_step (
        .i_r    (r_r),
        .i_q    (r_q),
        .i_pair (r_num[WIDTH-1 -: 2]),
        .o_r    (w_r_nxt),
        .o_q    (w_q_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Operand is consumed MSB pair first by shifting it left each iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num   <= '0;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_exact <= 1'b0;
        end else if (w_accept) begin
            r_num   <= in_num;
            r_cnt   <= CW'(N - 1);
            r_r     <= '0;
            r_q     <= '0;
            r_exact <= 1'b0;
        end else if (r_state == ST_CALC) begin
            r_num <= r_num << 2;
            r_r   <= w_r_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt == '0) begin
                r_exact <= (w_r_nxt == '0);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign root  = r_q;
    assign rem   = r_r[N:0];
    assign exact = r_exact;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and exhaustive checks of isqrt_seq at WIDTH=6, plus a WIDTH=8 case.
module tb_isqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, exact;
    logic [5:0] in_num;
    logic [2:0] root;
    logic [3:0] rem;

    logic       d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready, d8_exact;
    logic [7:0] d8_in_num;
    logic [3:0] d8_root;
    logic [4:0] d8_rem;

    int n_chk = 0;
    int n_err = 0;

    isqrt_seq #(.WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .root(root), .rem(rem), .exact(exact)
    );

    isqrt_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_num(d8_in_num),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .root(d8_root), .rem(d8_rem), .exact(d8_exact)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int isqrt_ref(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int square(input int v);
        return v * v;
    endfunction

    task automatic start6(input logic [5:0] num, output int lat);
        in_num   = num;
        in_valid = 1'b1;
        check("accept_rdy", {31'd0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_rdy", {31'd0, in_ready}, 0);
            tick();
            lat++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 1);
    endtask

    task automatic finish6();
        out_ready = 1'b1;
        tick();
        check("drop_vld", {31'd0, out_valid}, 0);
        check("idle_rdy", {31'd0, in_ready}, 1);
    endtask

    task automatic op6(input logic [5:0] num, input int er, input int erem, input int eex);
        int lat;
        start6(num, lat);
        check("latency", lat, 3);
        check("root", {29'd0, root}, er);
        check("rem", {28'd0, rem}, erem);
        check("exact", {31'd0, exact}, eex);
        check("upper_zero", {30'd0, dut6.r_r[5:4]}, 0);
        finish6();
    endtask

    initial begin
        int lat;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_num       = '0;
        out_ready    = 1'b1;
        d8_in_valid  = 1'b0;
        d8_in_num    = '0;
        d8_out_ready = 1'b1;
        repeat (2) tick();
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_root", {29'd0, root}, 0);
        check("rst_rem", {28'd0, rem}, 0);
        check("rst_exact", {31'd0, exact}, 0);
        check("rst8_in_ready", {31'd0, d8_in_ready}, 1);
        rst_n = 1'b1;
        tick();

        // WIDTH=8 regression
        d8_in_num   = 8'd255;
        d8_in_valid = 1'b1;
        check("w8_accept_rdy", {31'd0, d8_in_ready}, 1);
        tick();
        d8_in_valid = 1'b0;
        lat = 0;
        while (!d8_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("w8_latency", lat, 4);
        check("w8_root", {28'd0, d8_root}, 15);
        check("w8_rem", {27'd0, d8_rem}, 30);
        check("w8_exact", {31'd0, d8_exact}, 0);
        tick();
        check("w8_drop_vld", {31'd0, d8_out_valid}, 0);

        op6(6'd36, 6, 0, 1);
        check("hold_root_idle", {29'd0, root}, 6);
        op6(6'd63, 7, 14, 0);
        op6(6'd10, 3, 1, 0);
        op6(6'd0, 0, 0, 1);

        // Backpressure with a competing operand presented throughout
        out_ready = 1'b0;
        start6(6'd49, lat);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_num   = 6'd3;
            tick();
            check("bp_vld", {31'd0, out_valid}, 1);
            check("bp_root", {29'd0, root}, 7);
            check("bp_rem", {28'd0, rem}, 0);
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_vld", {31'd0, out_valid}, 0);
        check("bp_release_rdy", {31'd0, in_ready}, 1);
        start6(6'd3, lat);
        check("bp_next_lat", lat, 3);
        check("bp_next_root", {29'd0, root}, 1);
        check("bp_next_rem", {28'd0, rem}, 2);
        check("bp_next_exact", {31'd0, exact}, 0);
        finish6();

        // Reset while in CALC
        in_num   = 6'd50;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {31'd0, out_valid}, 0);
        check("mid_rst_rdy", {31'd0, in_ready}, 1);
        check("mid_rst_root", {29'd0, root}, 0);
        check("mid_rst_rem", {28'd0, rem}, 0);
        check("mid_rst_exact", {31'd0, exact}, 0);
        rst_n = 1'b1;
        tick();
        op6(6'd25, 5, 0, 1);

        // Exhaustive sweep with random gaps and backpressure
        for (int x = 0; x < 64; x++) begin
            int r, m, xl, gap;
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            out_ready = 1'b0;
            start6(x[5:0], xl);
            check("ex_latency", xl, 3);
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            check("ex_hold_vld", {31'd0, out_valid}, 1);
            r = int'(root);
            m = int'(rem);
            check("ex_sum", r * r + m, x);
            check("ex_rem_bound", {31'd0, m <= 2 * r}, 1);
            check("ex_exact", {31'd0, exact}, {31'd0, m == 0});
            check("ex_root", r, isqrt_ref(x));
            if (exact) check("ex_square", square(r), x);
            finish6();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
